// File: rtl/pwm_duty_decoder_pkg.sv
// pwm_duty_decoder_pkg: duty codes, FSM states and defaults shared by the PWM generator and decoder
package pwm_duty_decoder_pkg;
  localparam logic [2:0] OPC_0   = 3'b000;
  localparam logic [2:0] OPC_25  = 3'b001;
  localparam logic [2:0] OPC_50  = 3'b010;
  localparam logic [2:0] OPC_75  = 3'b011;
  localparam logic [2:0] OPC_100 = 3'b100;
  localparam int DEFAULT_PERIOD = 100000;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: two-flop synchronizer plus edge flop producing rise/fall strobes
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  output logic s,
  output logic rise,
  output logic fall
);
  logic s1, p;
  // Shift the asynchronous input through s1 -> s -> p
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {p, s, s1} <= '0;
    else {p, s, s1} <= {s, s1, pwm_i};
  assign rise = s & ~p;
  assign fall = ~s & p;
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures PWM period, high time and nearest duty step, with edge-loss timeout
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int Width         = 17,
  parameter int TimeoutCycles = 120000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pwm_i,
  output logic [Width-1:0] period_o,
  output logic [Width-1:0] high_o,
  output logic [2:0]       opc_o,
  output logic             valid_o,
  output logic             timeout_o
);
  localparam logic [Width-1:0] CntMax  = '1;
  localparam logic [Width-1:0] One     = Width'(1);
  localparam logic [Width-1:0] ToLimit = Width'(TimeoutCycles);
  logic s, rise, fall, edge_seen, expire;
  state_e state_q, state_d;
  logic [Width-1:0] per_q, per_d, hi_q, hi_d, to_q, to_d, per_inc, hi_inc, period_d, high_d;
  logic [2:0] opc_d, cls;
  logic valid_d, timeout_d;
  logic [Width+2:0] h8, p1, p3, p5, p7;

  pwm_sync_edge u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pwm_i(pwm_i),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // Divide-free duty classification of the counts about to be latched
  always_comb begin
    h8  = {hi_q, 3'b000};
    p1  = {3'b000, per_q};
    p3  = (p1 << 1) + p1;
    p5  = (p1 << 2) + p1;
    p7  = (p1 << 3) - p1;
    cls = h8 < p1 ? OPC_0 : h8 < p3 ? OPC_25 : h8 < p5 ? OPC_50 : h8 < p7 ? OPC_75 : OPC_100;
  end

  // Next state, saturating counters, timeout detection and output latching
  always_comb begin
    edge_seen = rise | fall;
    expire    = !edge_seen && to_q == ToLimit - One;
    to_d      = edge_seen ? '0 : to_q == ToLimit ? to_q : to_q + One;
    per_inc   = per_q == CntMax ? per_q : per_q + One;
    hi_inc    = hi_q == CntMax ? hi_q : hi_q + One;
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    period_d  = period_o;
    high_d    = high_o;
    opc_d     = opc_o;
    valid_d   = 1'b0;
    timeout_d = timeout_o;
    case (state_q)
      IDLE: if (rise) begin
        state_d = HIGH;
        per_d   = One;
        hi_d    = One;
      end
      HIGH: begin
        per_d = per_inc;
        if (fall) state_d = LOW;
        else hi_d = hi_inc;
      end
      LOW: if (rise) begin
        period_d  = per_q;
        high_d    = hi_q;
        opc_d     = cls;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
        state_d   = HIGH;
        per_d     = One;
        hi_d      = One;
      end else per_d = per_inc;
      default: state_d = IDLE;
    endcase
    if (expire) begin
      timeout_d = 1'b1;
      period_d  = '0;
      high_d    = '0;
      opc_d     = s ? OPC_100 : OPC_0;
      valid_d   = 1'b1;
      state_d   = IDLE;
      per_d     = '0;
      hi_d      = '0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q   <= IDLE;
      per_q     <= '0;
      hi_q      <= '0;
      to_q      <= '0;
      period_o  <= '0;
      high_o    <= '0;
      opc_o     <= OPC_0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      to_q      <= to_d;
      period_o  <= period_d;
      high_o    <= high_d;
      opc_o     <= opc_d;
      valid_o   <= valid_d;
      timeout_o <= timeout_d;
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: table vectors, directed corner sequences and random waveforms against a duty-ratio model
module tb_pwm_duty_decoder;
  localparam int W = 17;
  localparam int T = 1500;
  logic clk = 1'b0, rst_i = 1'b1, pwm_i = 1'b0;
  logic [W-1:0] period_o, high_o;
  logic [2:0] opc_o;
  logic valid_o, timeout_o;

  always #5 clk = ~clk;

  pwm_duty_decoder #(.Width(W), .TimeoutCycles(T)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .pwm_i    (pwm_i),
    .period_o (period_o),
    .high_o   (high_o),
    .opc_o    (opc_o),
    .valid_o  (valid_o),
    .timeout_o(timeout_o)
  );

  typedef struct {int period; int high; int opc; int to;} rep_t;
  typedef struct {int hi; int lo; int period; int high; int opc;} vec_t;
  rep_t exp_q[$];
  vec_t tbl[8];
  int n_checks = 0, n_fail = 0, nvalid = 0;
  int last_period, last_high, last_opc, last_to;
  bit m_lvl, m_armed;
  int m_hi, m_lo, m_run;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // nearest quarter step of the duty ratio, ties rounding up
  function automatic int ref_opc(input int h, input int p);
    real r;
    r = 4.0 * h / p;
    return $rtoi($floor(r + 0.5));
  endfunction

  function automatic void model_reset();
    m_lvl = 0; m_armed = 0; m_hi = 0; m_lo = 0; m_run = 0;
  endfunction

  // drive a constant level for n clocks and predict the reports it causes
  task automatic seg(input bit lvl, input int n);
    if (lvl != m_lvl) begin
      if (lvl) begin
        if (m_armed) exp_q.push_back('{m_hi + m_lo, m_hi, ref_opc(m_hi, m_hi + m_lo), 0});
        m_armed = 1; m_hi = 0; m_lo = 0;
      end
      m_run = 0;
      m_lvl = lvl;
    end
    if (m_run <= T && m_run + n > T) begin
      exp_q.push_back('{0, 0, lvl ? 4 : 0, 1});
      m_armed = 0;
    end
    m_run += n;
    if (lvl) m_hi += n; else m_lo += n;
    pwm_i = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    pwm_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " period_o"}, int'(period_o), 0);
    check({tag, " high_o"}, int'(high_o), 0);
    check({tag, " opc_o"}, int'(opc_o), 0);
    check({tag, " valid_o"}, int'(valid_o), 0);
    check({tag, " timeout_o"}, int'(timeout_o), 0);
  endtask

  // scoreboard: every valid_o pulse must match the next predicted report
  initial begin
    rep_t e;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        nvalid++;
        last_period = int'(period_o);
        last_high = int'(high_o);
        last_opc = int'(opc_o);
        last_to = int'(timeout_o);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected report: got period %0d high %0d opc %0d, expected no valid_o", period_o, high_o, opc_o);
        end else begin
          e = exp_q.pop_front();
          check("report period_o", last_period, e.period);
          check("report high_o", last_high, e.high);
          check("report opc_o", last_opc, e.opc);
          check("report timeout_o", last_to, e.to);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    tbl[0] = '{250, 751, 1001, 250, 1};
    tbl[1] = '{500, 501, 1001, 500, 2};
    tbl[2] = '{750, 251, 1001, 750, 3};
    tbl[3] = '{99, 701, 800, 99, 0};
    tbl[4] = '{100, 700, 800, 100, 1};
    tbl[5] = '{699, 101, 800, 699, 3};
    tbl[6] = '{700, 100, 800, 700, 4};
    tbl[7] = '{1, 2, 3, 1, 1};
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      n0 = nvalid;
      seg(0, 4);
      for (int k = 0; k < 3; k++) begin
        seg(1, tbl[i].hi);
        seg(0, tbl[i].lo);
      end
      repeat (6) @(negedge clk);
      check($sformatf("vec%0d reports", i), nvalid - n0, 2);
      check($sformatf("vec%0d period_o", i), int'(period_o), tbl[i].period);
      check($sformatf("vec%0d high_o", i), int'(high_o), tbl[i].high);
      check($sformatf("vec%0d opc_o", i), int'(opc_o), tbl[i].opc);
      check($sformatf("vec%0d timeout_o", i), int'(timeout_o), 0);
    end
    do_reset();
    n0 = nvalid;
    seg(0, 2 * T);
    check("static low reports", nvalid - n0, 1);
    check("static low opc", last_opc, 0);
    check("static low period", last_period, 0);
    check("static low high", last_high, 0);
    check("static low timeout_o", int'(timeout_o), 1);
    n0 = nvalid;
    seg(1, 2 * T);
    check("static high reports", nvalid - n0, 1);
    check("static high opc", last_opc, 4);
    check("static high timeout_o", int'(timeout_o), 1);
    n0 = nvalid;
    seg(0, 501);
    seg(1, 500);
    check("resume first rise timeout_o", int'(timeout_o), 1);
    check("resume first rise reports", nvalid - n0, 0);
    seg(0, 501);
    seg(1, 500);
    check("resume reports", nvalid - n0, 1);
    check("resume timeout_o", int'(timeout_o), 0);
    check("resume opc", last_opc, 2);
    check("resume period", last_period, 1001);
    do_reset();
    seg(0, 3);
    seg(1, 300);
    seg(0, 301);
    seg(1, 300);
    check("pre-reset period", int'(period_o), 601);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1 check_zero("async reset");
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    n0 = nvalid;
    seg(1, 200);
    seg(0, 100);
    check("post-reset single rise reports", nvalid - n0, 0);
    seg(1, 150);
    seg(0, 50);
    check("post-reset reports", nvalid - n0, 1);
    check("post-reset period", last_period, 300);
    check("post-reset high", last_high, 200);
    check("post-reset opc", last_opc, 3);
    do_reset();
    for (int k = 0; k < 80; k++) seg(k % 2 == 0, $urandom_range(1, 500));
    seg(0, 10);
    repeat (8) @(negedge clk);
    check("pending reports", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
